// File: rtl/pc_uart_tx_sched.sv
// pc_uart_tx_sched: shares one byte-wide UART transmitter between two
// requesters that each hand over a whole FRAME_BYTES-byte frame.
// Arbitration is round-robin, and the winner keeps the grant until its frame is done.
// The frame is captured at grant time and sent MSB byte first through the
// transmitter's tx_start/tx_data/tx_rdy handshake.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req0/req1         level requests, held until the matching done pulse
//   frame0/frame1     frames; byte [8*FRAME_BYTES-1 -: 8] is sent first
//   gnt0/gnt1         requester owns the transmitter (grant through done)
//   done0/done1       one-cycle pulse when that requester's frame has gone out
//   busy              scheduler not in IDLE
//   tx_start/tx_data  one-cycle start pulse and the byte to send
//   tx_rdy            transmitter idle; drops the cycle after a start is taken
module pc_uart_tx_sched #(
    parameter int FRAME_BYTES = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0,
    input  logic [8*FRAME_BYTES-1:0] frame0,
    input  logic                     req1,
    input  logic [8*FRAME_BYTES-1:0] frame1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     done0,
    output logic                     done1,
    output logic                     busy,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_rdy
);

    localparam int FW = 8 * FRAME_BYTES;
    localparam int IW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state, state_nxt;
    logic [FW-1:0] sh;        // frame in flight, current byte at the top
    logic [FW-1:0] sh_adv;
    logic [FW-1:0] sel_frame;
    logic [IW-1:0] idx;
    logic          rr;        // 1: requester 1 wins a tie
    logic          win;       // 1: requester 1 wins this arbitration
    logic          grant, advance, finish, last;

    assign last      = (idx == IW'(FRAME_BYTES - 1));
    assign sh_adv    = sh << 8;
    assign win       = (req0 && req1) ? rr : req1;
    assign sel_frame = win ? frame1 : frame0;

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE:      if ((req0 || req1) && tx_rdy) begin
                           grant     = 1'b1;
                           state_nxt = LOAD;
                       end
            LOAD:      state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!tx_rdy) state_nxt = WAIT_DONE;
            WAIT_DONE: if (tx_rdy) begin
                           if (last) begin
                               finish    = 1'b1;
                               state_nxt = IDLE;
                           end else begin
                               advance   = 1'b1;
                               state_nxt = LOAD;
                           end
                       end
            default:   state_nxt = IDLE;
        endcase
    end

    // done is taken straight from the WAIT_DONE exit so it lands in the very
    // cycle the grant is released; gnt is still high during that cycle.
    assign tx_start = (state == LOAD);
    assign busy     = (state != IDLE);
    assign done0    = finish && gnt0;
    assign done1    = finish && gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sh      <= '0;
            idx     <= '0;
            rr      <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            tx_data <= 8'h00;
        end else begin
            state <= state_nxt;
            if (grant) begin
                sh      <= sel_frame;
                tx_data <= sel_frame[FW-1 -: 8];
                idx     <= '0;
                gnt0    <= ~win;
                gnt1    <= win;
            end
            // tx_data is loaded on the way into LOAD, so it is already valid
            // while tx_start is high and stays put until the next LOAD.
            if (advance) begin
                sh      <= sh_adv;
                tx_data <= sh_adv[FW-1 -: 8];
                idx     <= idx + IW'(1);
            end
            if (finish) begin
                gnt0 <= 1'b0;
                gnt1 <= 1'b0;
                rr   <= gnt0;   // favour whoever was not just served
            end
        end
    end

endmodule

// File: doc/pc_uart_tx_sched.md
Name: pc_uart_tx_sched

Overview:
Two-requester frame scheduler that sits in front of the PC-side UART transmitter and shares it between two requesters. Each requester hands over a complete multi-byte frame. The scheduler arbitrates round-robin and serialises the winning frame byte-by-byte, MSB byte first, into the transmitter's tx_start/tx_data/tx_rdy handshake. It signals per-requester completion.

Parameters:
FRAME_BYTES, 3, bytes per frame; frame ports are 8*FRAME_BYTES wide; legal range 1..8.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
req0  input  1  requester 0 frame request, level, held until done0
frame0  input  8*FRAME_BYTES  requester 0 frame; byte [8*FRAME_BYTES-1 -: 8] sent first
req1  input  1  requester 1 frame request, level, held until done1
frame1  input  8*FRAME_BYTES  requester 1 frame
gnt0  output  1  requester 0 owns transmitter (grant through done)
gnt1  output  1  requester 1 owns transmitter
done0  output  1  one-cycle pulse: requester 0 frame fully transmitted
done1  output  1  one-cycle pulse: requester 1 frame fully transmitted
busy  output  1  high in any state other than IDLE
tx_start  output  1  to transmitter: one-cycle start pulse
tx_data  output  8  to transmitter: byte to send
tx_rdy  input  1  from transmitter: high when idle; drops the cycle after tx_start is accepted

Behaviour:
- Reset (async, any state): state=IDLE, gnt0=gnt1=0, done0=done1=0, busy=0, tx_start=0, tx_data=8'h00, byte index=0, round-robin pointer favours requester 0.
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE: if (req0|req1) && tx_rdy:
  - pick winner: only one requesting -> that one; both -> the one not served last (after reset: req0).
  - capture the winner's frame into the shift register; set gnt for the winner; index=0; go to LOAD.
  - If tx_rdy=0, no grant; stay in IDLE.
- LOAD: tx_start=1 for exactly this cycle; tx_data = top byte of the shift register; go to WAIT_BUSY.
- WAIT_BUSY: wait for tx_rdy=0, then go to WAIT_DONE. Never reissue tx_start.
- WAIT_DONE: on tx_rdy=1:
  - if index==FRAME_BYTES-1: pulse done for the granted requester, clear its gnt, point round-robin at the other requester, go to IDLE.
  - otherwise: index+1, shift frame left 8, go to LOAD.
- tx_data is registered and held stable from LOAD until the next LOAD. tx_start is asserted only in LOAD.
- Latency: req high with IDLE and tx_rdy=1 at edge N -> gnt high after edge N -> tx_start high in cycle N+1.
- Frame capture happens at grant only. Later changes to frameX, or dropping reqX mid-frame, do not affect the frame in flight; it completes and done still pulses.
- A requester still asserting req in the done cycle is re-arbitrated in the following IDLE cycle. If the other requester is waiting, the other requester wins. Minimum one IDLE cycle between frames.
- gnt0 and gnt1 are never both high. done pulses only in the cycle the state leaves WAIT_DONE for IDLE.
- Index width is clog2(FRAME_BYTES), minimum 1 bit. Index never wraps within a frame.

Test Plan:
- Single frame: req0=1, frame0=24'hA55A3C, transmitter model with tx_rdy low for 20 cycles per byte -> exactly three tx_start pulses carrying 8'hA5, 8'h5A, 8'h3C in order; gnt0 high throughout; one done0 pulse after the third tx_rdy rise; busy returns to 0.
- Contention after reset: req0 and req1 rise in the same cycle, frame0=24'h111111, frame1=24'h222222 -> the 0x11 frame is sent completely, then the 0x22 frame; done0 precedes done1; gnt never overlaps.
- Fairness: req0 and req1 held high for 4 frames -> grant order 0,1,0,1; four done pulses alternate.
- Mid-frame disturbance: after the first tx_start, drop req1 and change frame1 from 24'hC0FFEE to 24'h000000 -> bytes C0, FF, EE are still sent; done1 pulses once.
- Transmitter busy: tx_rdy held 0 while req0=1 for 50 cycles -> no gnt and no tx_start; grant follows one cycle after tx_rdy rises.
- Reset mid-frame: assert rst_n=0 during WAIT_DONE of byte 2 -> all outputs go to reset values immediately; after release with req0=1, the frame restarts from its first byte.
